// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous instruction ROM port between
// CPU fetch (priority) and a debug reader, with starvation bound.
//
// Ports:
//   clk, reset (sync, active-low), ena (global grant enable)
//   fetch_req/fetch_addr -> fetch_gnt, fetch_rvalid, fetch_rdata
//   dbg_req/dbg_addr     -> dbg_gnt, dbg_rvalid, dbg_rdata
//   rom_ena, rom_addr (sign-extended) -> ROM; rom_data <- ROM douta
module imem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rom_ena,
  output logic [31:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic v;
    logic dbg;
  } tag_t;

  logic [CW-1:0]     wait_cnt;
  logic              live;
  logic              starve;
  logic              dgnt;
  logic              fgnt;
  logic [ADDR_W-1:0] sel_addr;
  tag_t              tag_q [ROM_LAT];
  tag_t              tag_out;

  always_comb begin
    live     = reset & ena;
    starve   = (wait_cnt >= CW'(MAX_WAIT));
    dgnt     = live & dbg_req & (~fetch_req | starve);
    fgnt     = live & fetch_req & ~dgnt;
    sel_addr = dgnt ? dbg_addr : fetch_addr;
  end

  assign fetch_gnt = fgnt;
  assign dbg_gnt   = dgnt;
  assign rom_ena   = fgnt | dgnt;
  assign rom_addr  = rom_ena
                   ? {{(32-ADDR_W){sel_addr[ADDR_W-1]}}, sel_addr}
                   : 32'h0;

  // Counts consecutive denials of a pending debug request.
  // Saturates at MAX_WAIT; at that point debug wins the next grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (ena) begin
      if (!dbg_req || dgnt) begin
        wait_cnt <= '0;
      end else if (!starve) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Owner tags ride alongside the ROM read; not stalled by ena.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0].v   <= fgnt | dgnt;
      tag_q[0].dbg <= dgnt;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[ROM_LAT-1];

  // A response falling due while reset is held is dropped, so the
  // valids are also qualified by reset, not only by the cleared tags.
  assign fetch_rvalid = reset & tag_out.v & ~tag_out.dbg;
  assign dbg_rvalid   = reset & tag_out.v & tag_out.dbg;
  assign fetch_rdata  = rom_data;
  assign dbg_rdata    = rom_data;

endmodule
